// File: rtl/pmu_level_scheduler.sv
// pmu_level_scheduler: round-robin speed-level request sequencer with PLL settle hold-off and idle drop
module pmu_level_scheduler #(
  parameter int NREQ = 3,
  parameter int LEVEL_W = 3,
  parameter int SETTLE_CYCLES = 64,
  parameter int IDLE_CYCLES = 1024,
  parameter logic [LEVEL_W-1:0] IDLE_LEVEL = 3'b000,
  parameter logic [LEVEL_W-1:0] RESET_LEVEL = 3'b101
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEVEL_W-1:0] req_level,
  input  logic                    activity,
  output logic [NREQ-1:0]         grant,
  output logic                    change_level_flag,
  output logic [LEVEL_W-1:0]      change_level,
  output logic [LEVEL_W-1:0]      current_level,
  output logic                    busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES) > 0 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IW = $clog2(IDLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);
  typedef enum logic {READY, SETTLE} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, win, idx;
  logic [SW-1:0] scnt, scnt_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [NREQ-1:0] elig, grant_n;
  logic found, flag_n;
  logic [LEVEL_W-1:0] cl_n, cur_n;
  logic [LEVEL_W-1:0] lvl [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_lvl
    assign lvl[g] = req_level[g*LEVEL_W +: LEVEL_W];
  end
  assign busy = state == SETTLE;
  // round-robin pick: first eligible requester at or above the pointer, wrapping
  always_comb begin
    elig = req & ~grant;
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // next state: settle countdown, request issue, idle timer and idle drop
  always_comb begin
    state_n = state;
    scnt_n = scnt;
    icnt_n = icnt;
    ptr_n = ptr;
    grant_n = '0;
    flag_n = 1'b0;
    cl_n = change_level;
    cur_n = current_level;
    if (state == SETTLE) begin
      state_n = scnt == '0 ? READY : SETTLE;
      scnt_n = scnt == '0 ? scnt : scnt - SW'(1);
      icnt_n = '0;
    end else if (found) begin
      grant_n[win] = 1'b1;
      cl_n = lvl[win];
      ptr_n = win == PW'(NREQ - 1) ? '0 : win + PW'(1);
      icnt_n = '0;
      if (lvl[win] != current_level) begin
        flag_n = 1'b1;
        cur_n = lvl[win];
        state_n = SETTLE;
        scnt_n = SETTLE_MAX;
      end
    end else if (activity || |req) begin
      icnt_n = '0;
    end else if (icnt == IDLE_MAX) begin
      if (current_level != IDLE_LEVEL) begin
        flag_n = 1'b1;
        cl_n = IDLE_LEVEL;
        cur_n = IDLE_LEVEL;
        state_n = SETTLE;
        scnt_n = SETTLE_MAX;
        icnt_n = '0;
      end
    end else begin
      icnt_n = icnt + IW'(1);
    end
  end
  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= READY;
      scnt <= '0;
      icnt <= '0;
      ptr <= '0;
      grant <= '0;
      change_level_flag <= 1'b0;
      change_level <= RESET_LEVEL;
      current_level <= RESET_LEVEL;
    end else begin
      state <= state_n;
      scnt <= scnt_n;
      icnt <= icnt_n;
      ptr <= ptr_n;
      grant <= grant_n;
      change_level_flag <= flag_n;
      change_level <= cl_n;
      current_level <= cur_n;
    end
  end
endmodule

// File: tb/tb_pmu_level_scheduler.sv
// tb_pmu_level_scheduler: scoreboard bench for the level scheduler
module tb_pmu_level_scheduler;
  logic clk = 1'b0, reset = 1'b1, activity = 1'b0;
  logic [2:0] req = '0;
  logic [8:0] req_level = '0;
  logic [2:0] grant, change_level, current_level;
  logic change_level_flag, busy;
  int cyc = 0, n_checks = 0, n_fail = 0, r = 0, n = 0;
  typedef struct packed {
    int c;
    logic [2:0] g;
    logic f;
    logic [2:0] cl;
    logic [2:0] cur;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  pmu_level_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .req_level(req_level), .activity(activity),
    .grant(grant), .change_level_flag(change_level_flag), .change_level(change_level),
    .current_level(current_level), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    req = req & ~grant;
  endtask

  task automatic expect_ev(input int c, input logic [2:0] g, input logic f, input logic [2:0] cl, input logic [2:0] cur);
    sb.push_back('{c: c, g: g, f: f, cl: cl, cur: cur});
  endtask

  task automatic set_level(input int i, input logic [2:0] l);
    req_level[i*3 +: 3] = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    activity = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    r = cyc;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    do begin
      tick();
      k++;
    end while ((req != 0 || busy) && k < bound);
    check("wait_idle", {req, busy}, 0);
  endtask

  // monitor: every grant or flag must match the next scoreboard entry, including its cycle
  initial forever begin
    @(negedge clk);
    if (!reset && (|grant || change_level_flag)) begin
      if (sb.size() == 0) check("sb_unexpected", {grant, change_level_flag, change_level}, 0);
      else begin
        e = sb.pop_front();
        check("sb_event", {cyc, grant, change_level_flag, change_level, current_level}, e);
      end
    end
  end

  initial begin
    repeat (2) tick();
    check("rst_grant", grant, 0);
    check("rst_flag", change_level_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_change_level", change_level, 3'b101);
    check("rst_current_level", current_level, 3'b101);
    reset = 1'b0;
    r = cyc;
    // test 1: single request, settle length
    set_level(1, 3'b010);
    req = 3'b010;
    expect_ev(cyc + 1, 3'b010, 1, 3'b010, 3'b010);
    tick();
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("t1_busy_len", n, 64);
    check("t1_level", current_level, 3'b010);
    // test 2: two held requests, then equal-level grant moves pointer to 1, then rotation 1,2,0
    do_reset();
    set_level(0, 3'b011);
    set_level(2, 3'b110);
    req = 3'b101;
    expect_ev(cyc + 1, 3'b001, 1, 3'b011, 3'b011);
    expect_ev(cyc + 66, 3'b100, 1, 3'b110, 3'b110);
    wait_idle(300);
    set_level(0, 3'b110);
    req = 3'b001;
    expect_ev(cyc + 1, 3'b001, 0, 3'b110, 3'b110);
    wait_idle(10);
    set_level(0, 3'b011);
    set_level(1, 3'b001);
    set_level(2, 3'b010);
    req = 3'b111;
    expect_ev(cyc + 1, 3'b010, 1, 3'b001, 3'b001);
    expect_ev(cyc + 66, 3'b100, 1, 3'b010, 3'b010);
    expect_ev(cyc + 131, 3'b001, 1, 3'b011, 3'b011);
    wait_idle(400);
    // test 3: equal level, no settle, next requester granted the following cycle
    set_level(2, 3'b011);
    set_level(0, 3'b100);
    req = 3'b101;
    expect_ev(cyc + 1, 3'b100, 0, 3'b011, 3'b011);
    expect_ev(cyc + 2, 3'b001, 1, 3'b100, 3'b100);
    tick();
    check("t3_busy", busy, 0);
    wait_idle(200);
    // test 4: idle drop after 1024 quiet cycles, then saturation at idle level
    do_reset();
    expect_ev(r + 1024, 3'b000, 1, 3'b000, 3'b000);
    repeat (1100) tick();
    check("t4_level", current_level, 3'b000);
    check("t4_busy", busy, 0);
    repeat (1100) tick();
    check("t4_saturate", current_level, 3'b000);
    // activity every 1022 cycles keeps the level up
    do_reset();
    for (int i = 0; i < 10; i++) begin
      activity = 1'b1;
      tick();
      activity = 1'b0;
      repeat (1021) tick();
    end
    check("t4_activity_level", current_level, 3'b101);
    // test 5: request in the idle-expiry cycle wins
    do_reset();
    set_level(0, 3'b010);
    while (cyc < r + 1023) tick();
    req = 3'b001;
    expect_ev(r + 1024, 3'b001, 1, 3'b010, 3'b010);
    wait_idle(200);
    check("t5_level", current_level, 3'b010);
    // test 6: reset mid-settle
    set_level(1, 3'b110);
    req = 3'b010;
    expect_ev(cyc + 1, 3'b010, 1, 3'b110, 3'b110);
    repeat (10) tick();
    check("t6_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_change_level", change_level, 3'b101);
    check("t6_current_level", current_level, 3'b101);
    check("t6_flag", change_level_flag, 0);
    tick();
    reset = 1'b0;
    repeat (100) tick();
    check("t6_after_busy", busy, 0);
    check("t6_after_level", current_level, 3'b101);
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
